rd_arbiter: RTL and testbench
=============================

# rd_arbiter

Multiplexes the DRAM read-request channels of `NUM_ENGINES` Smith-Waterman engines onto one shared AXI-style read port, and steers returning read data back to the engine that issued each burst. It sits directly downstream of the engines' reference-reader read interface (`rd_*`) and upstream of the memory controller. Requests are granted round-robin. The memory port returns bursts strictly in request order, so routing uses an in-order grant FIFO and a beat counter.

## Interface
- `NUM_ENGINES`, 4, number of engine read clients (2..16)
- `ENG_IDX_W`, 2, clog2(NUM_ENGINES)
- `MAX_OUTSTANDING`, 8, grant FIFO depth in bursts (power of two)
- `DATA_W`, 256, read data width
---
- `clk`  in  1  engine/arbiter clock
- `rst`  in  1  synchronous, active-high reset
- `e_rd_id_in`  in  NUM_ENGINES*6  per-engine burst ID, engine i at [6i+5:6i]
- `e_rd_addr_in`  in  NUM_ENGINES*32  per-engine burst address
- `e_rd_len_in`  in  NUM_ENGINES*8  per-engine burst length; beats = len+1
- `e_rd_info_valid_in`  in  NUM_ENGINES  request valid
- `e_rd_info_rdy_out`  out  NUM_ENGINES  request accepted (one-hot or zero)
- `e_rd_data_out`  out  DATA_W  read data, broadcast to all engines
- `e_rd_data_valid_out`  out  NUM_ENGINES  data valid, one-hot to the owning engine
- `e_rd_data_rdy_in`  in  NUM_ENGINES  engine data ready
- `m_rd_id_out`  out  6+ENG_IDX_W  `{engine index, engine id}`
- `m_rd_addr_out`  out  32  memory burst address
- `m_rd_len_out`  out  8  memory burst length
- `m_rd_info_valid_out`  out  1  memory request valid
- `m_rd_info_rdy_in`  in  1  memory request accepted
- `m_rd_data_in`  in  DATA_W  memory read data
- `m_rd_data_valid_in`  in  1  memory data valid
- `m_rd_data_rdy_out`  out  1  memory data accepted
- `id_err_out`  out  1  sticky; exists only with `RD_ARB_ID_CHECK_EN`
- `m_rd_data_id_in`  in  6+ENG_IDX_W  returned ID; exists only with `RD_ARB_ID_CHECK_EN`

## Operation
- **Request stage.** The request stage is one output register with states IDLE and HOLD.
  - In IDLE, when the grant FIFO is not full and any `e_rd_info_valid_in` is high, the arbiter picks the first requester at or after `rr_ptr`, cyclically.
  - It asserts `e_rd_info_rdy_out[g]` combinationally in that cycle and loads the register with `{g, id, addr, len}`.
  - On the same edge it pushes `{g, len}` into the grant FIFO and sets `rr_ptr = g+1`, wrapping modulo NUM_ENGINES.
  - The stage then moves to HOLD.
- **HOLD.** `m_rd_info_valid_out` is 1 and the register contents stay stable until `m_rd_info_rdy_in`; the stage then returns to IDLE.
- **Throughput.** No new grant is made in the same cycle as the HOLD handshake, so the maximum rate is one request per 2 cycles.
- **Data stage.** Routing is combinational from the FIFO head `{h, hlen}`.
  - When the FIFO is non-empty: `e_rd_data_valid_out[h] = m_rd_data_valid_in` and `m_rd_data_rdy_out = e_rd_data_rdy_in[h]`.
  - When the FIFO is empty: all valids are 0 and `m_rd_data_rdy_out` is 0.
- **Beat counting.** `beat_cnt` (8 bits) increments on each data handshake. When `beat_cnt == hlen` on a handshake, the FIFO pops and `beat_cnt` clears.
- **FIFO full/empty.** A push on a full FIFO is impossible because grants are blocked when full. A push and a pop in the same cycle are both performed.
- **Reset mid-operation.** Reset drops the HOLD request, empties the FIFO and clears `beat_cnt` and `rr_ptr`. In-flight memory bursts are the system's responsibility to quiesce.

## Timing
- Reset values: all `*_valid_out`, `*_rdy_out` and `id_err_out` are 0; `m_rd_*` payload is 0; `rr_ptr`, `beat_cnt` and the FIFO count are 0.
- Engine request to `m_rd_info_valid_out`: 1 cycle.
- Data path: 0-cycle latency, fully combinational valid/ready/data.
- The arbiter holds no data beats.

## Configuration
- Macro: `RD_ARB_ID_CHECK_EN`.
- **Defined:**
  - Adds `m_rd_data_id_in` and `id_err_out`.
  - On each data handshake, if `m_rd_data_id_in[6+ENG_IDX_W-1:6] != h`, `id_err_out` sets.
  - `id_err_out` also sets when `m_rd_data_valid_in` is high with the FIFO empty.
  - `id_err_out` clears only on `rst`.
- **Undefined:** neither port exists, and no checking logic is generated.

## Structure
- Shared package `sw_pkg` holds:
  - `RD_ID_W = 6`, `RD_ADDR_W = 32`, `RD_LEN_W = 8`, `RD_DATA_W = 256`;
  - the typedef `rd_grant_t {eng_idx, len}`.
- One sub-module: `grant_fifo`, a synchronous FIFO of `rd_grant_t` with depth MAX_OUTSTANDING, full/empty flags and show-ahead head.

## Test plan
- **Single request.** Engine 2 requests addr 0x1000, len 3, id 5. Expected:
  - `m_rd_id_out = {2'd2, 6'd5}`, with valid 1 cycle later.
  - 4 beats route only to `e_rd_data_valid_out[2]`, and the FIFO empties after beat 4.
- **Round-robin.** All 4 engines request continuously with len 0. Expected grant order 0,1,2,3,0,…, one grant every 2 cycles while `m_rd_info_rdy_in` = 1.
- **Full FIFO.** Hold data valid low and issue 8 grants; a 9th requester sees rdy = 0 until the first burst completes.
- **Backpressure.** Engine 1 holds `e_rd_data_rdy_in` = 0 for 5 cycles mid-burst. Expected:
  - `m_rd_data_rdy_out` stays 0 for those cycles;
  - `beat_cnt` is unchanged;
  - data is delivered in order afterwards.
- **Reset mid-operation.** Assert `rst` while in HOLD with 3 FIFO entries. The next cycle shows all outputs 0, the FIFO empty and `rr_ptr` = 0.
- **ID check (`RD_ARB_ID_CHECK_EN`).** Return data tagged engine 3 while the head is engine 1; `id_err_out` rises next cycle and stays high.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared read-path types and widths for the Smith-Waterman engine cluster.
package sw_pkg;

  localparam int unsigned RD_ID_W          = 6;
  localparam int unsigned RD_ADDR_W        = 32;
  localparam int unsigned RD_LEN_W         = 8;
  localparam int unsigned RD_DATA_W        = 256;
  // Engine index field is sized for the largest supported cluster (16 engines).
  localparam int unsigned RD_ENG_IDX_MAX_W = 4;

  typedef struct packed {
    logic [RD_ENG_IDX_MAX_W-1:0] eng_idx;
    logic [RD_LEN_W-1:0]         len;
  } rd_grant_t;

  typedef enum logic [0:0] {
    StIdle,
    StHold
  } rd_req_state_e;

endpackage

// File: rtl/rd_arbiter_if.sv
// Engine-side and memory-side read channels of rd_arbiter.
// Optional ID-check signals exist only when RD_ARB_ID_CHECK_EN is defined.
interface rd_arbiter_if
  import sw_pkg::*;
#(
  parameter int unsigned NUM_ENGINES = 4,
  parameter int unsigned ENG_IDX_W   = 2,
  parameter int unsigned DATA_W      = 256
);

  logic [NUM_ENGINES*RD_ID_W-1:0]   e_rd_id_in;
  logic [NUM_ENGINES*RD_ADDR_W-1:0] e_rd_addr_in;
  logic [NUM_ENGINES*RD_LEN_W-1:0]  e_rd_len_in;
  logic [NUM_ENGINES-1:0]           e_rd_info_valid_in;
  logic [NUM_ENGINES-1:0]           e_rd_info_rdy_out;
  logic [DATA_W-1:0]                e_rd_data_out;
  logic [NUM_ENGINES-1:0]           e_rd_data_valid_out;
  logic [NUM_ENGINES-1:0]           e_rd_data_rdy_in;

  logic [RD_ID_W+ENG_IDX_W-1:0]     m_rd_id_out;
  logic [RD_ADDR_W-1:0]             m_rd_addr_out;
  logic [RD_LEN_W-1:0]              m_rd_len_out;
  logic                             m_rd_info_valid_out;
  logic                             m_rd_info_rdy_in;
  logic [DATA_W-1:0]                m_rd_data_in;
  logic                             m_rd_data_valid_in;
  logic                             m_rd_data_rdy_out;

`ifdef RD_ARB_ID_CHECK_EN
  logic [RD_ID_W+ENG_IDX_W-1:0]     m_rd_data_id_in;
  logic                             id_err_out;
`endif

  // Arbiter view.
  modport slave (
`ifdef RD_ARB_ID_CHECK_EN
    input  m_rd_data_id_in,
    output id_err_out,
`endif
    input  e_rd_id_in, e_rd_addr_in, e_rd_len_in, e_rd_info_valid_in, e_rd_data_rdy_in,
    input  m_rd_info_rdy_in, m_rd_data_in, m_rd_data_valid_in,
    output e_rd_info_rdy_out, e_rd_data_out, e_rd_data_valid_out,
    output m_rd_id_out, m_rd_addr_out, m_rd_len_out, m_rd_info_valid_out, m_rd_data_rdy_out
  );

  // Engines plus memory controller view.
  modport master (
`ifdef RD_ARB_ID_CHECK_EN
    output m_rd_data_id_in,
    input  id_err_out,
`endif
    output e_rd_id_in, e_rd_addr_in, e_rd_len_in, e_rd_info_valid_in, e_rd_data_rdy_in,
    output m_rd_info_rdy_in, m_rd_data_in, m_rd_data_valid_in,
    input  e_rd_info_rdy_out, e_rd_data_out, e_rd_data_valid_out,
    input  m_rd_id_out, m_rd_addr_out, m_rd_len_out, m_rd_info_valid_out, m_rd_data_rdy_out
  );

endinterface

// File: rtl/grant_fifo.sv
// In-order FIFO of issued grants with show-ahead head; Depth must be a power of two.
module grant_fifo
  import sw_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  rd_grant_t wdata_i,
  input  logic      pop_i,
  output rd_grant_t rdata_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW:0] DepthCnt = Depth[PtrW:0];

  rd_grant_t       mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q, count_d;
  logic            push_en, pop_en;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/rd_arbiter.sv
// Round-robin read-request arbiter with in-order data steering back to engines.
// Optional returned-ID checking is enabled by defining RD_ARB_ID_CHECK_EN.
module rd_arbiter
  import sw_pkg::*;
#(
  parameter int unsigned NUM_ENGINES     = 4,
  parameter int unsigned ENG_IDX_W       = 2,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned DATA_W          = 256
) (
  input logic        clk,
  input logic        rst,
  rd_arbiter_if.slave bus
);

  rd_req_state_e                state_q, state_d;
  logic [ENG_IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [RD_ID_W+ENG_IDX_W-1:0] m_id_q, m_id_d;
  logic [RD_ADDR_W-1:0]         m_addr_q, m_addr_d;
  logic [RD_LEN_W-1:0]          m_len_q, m_len_d;
  logic [RD_LEN_W-1:0]          beat_cnt_q, beat_cnt_d;

  logic [ENG_IDX_W-1:0]   gnt_idx, head_idx;
  logic                   gnt_found, grant_en;
  logic                   fifo_full, fifo_empty, data_hs, pop;
  logic                   m_data_rdy, unused_head_bits;
  logic [NUM_ENGINES-1:0] info_rdy, data_valid;
  logic [DATA_W-1:0]      rd_data;
  rd_grant_t              push_rec, head;

  // First requester at or after rr_ptr_q, searched cyclically.
  always_comb begin : arbitrate
    int unsigned          cand;
    logic [ENG_IDX_W-1:0] cand_idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
      cand = 32'(rr_ptr_q) + i;
      if (cand >= NUM_ENGINES) cand = cand - NUM_ENGINES;
      cand_idx = ENG_IDX_W'(cand);
      if (!gnt_found && bus.e_rd_info_valid_in[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  assign grant_en = (state_q == StIdle) && !fifo_full && gnt_found && !rst;

  always_comb begin
    info_rdy = '0;
    if (grant_en) info_rdy[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    m_id_d   = m_id_q;
    m_addr_d = m_addr_q;
    m_len_d  = m_len_q;
    unique case (state_q)
      StIdle: begin
        if (grant_en) begin
          state_d  = StHold;
          m_id_d   = {gnt_idx, bus.e_rd_id_in[32'(gnt_idx)*RD_ID_W +: RD_ID_W]};
          m_addr_d = bus.e_rd_addr_in[32'(gnt_idx)*RD_ADDR_W +: RD_ADDR_W];
          m_len_d  = bus.e_rd_len_in[32'(gnt_idx)*RD_LEN_W +: RD_LEN_W];
          rr_ptr_d = (32'(gnt_idx) == NUM_ENGINES - 1) ? '0 : gnt_idx + 1'b1;
        end
      end
      StHold: begin
        if (bus.m_rd_info_rdy_in) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      m_id_q     <= '0;
      m_addr_q   <= '0;
      m_len_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      m_id_q     <= m_id_d;
      m_addr_q   <= m_addr_d;
      m_len_q    <= m_len_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign push_rec.eng_idx = RD_ENG_IDX_MAX_W'(gnt_idx);
  assign push_rec.len     = bus.e_rd_len_in[32'(gnt_idx)*RD_LEN_W +: RD_LEN_W];

  grant_fifo #(
    .Depth (MAX_OUTSTANDING)
  ) u_grant_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (grant_en),
    .wdata_i (push_rec),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_idx         = head.eng_idx[ENG_IDX_W-1:0];
  assign unused_head_bits = ^head.eng_idx;

  // Data path is pure steering: memory bursts return in grant order.
  always_comb begin
    data_valid = '0;
    m_data_rdy = 1'b0;
    if (!fifo_empty) begin
      data_valid[head_idx] = bus.m_rd_data_valid_in;
      m_data_rdy           = bus.e_rd_data_rdy_in[head_idx];
    end
  end

  assign data_hs = bus.m_rd_data_valid_in && m_data_rdy;
  assign pop     = data_hs && (beat_cnt_q == head.len);

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (data_hs) beat_cnt_d = pop ? '0 : beat_cnt_q + 1'b1;
  end

`ifdef RD_ARB_ID_CHECK_EN
  logic id_err_q, id_err_d;

  always_comb begin
    id_err_d = id_err_q;
    if (data_hs && (bus.m_rd_data_id_in[RD_ID_W+ENG_IDX_W-1:RD_ID_W] != head_idx)) begin
      id_err_d = 1'b1;
    end
    if (bus.m_rd_data_valid_in && fifo_empty) id_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) id_err_q <= 1'b0;
    else     id_err_q <= id_err_d;
  end

  assign bus.id_err_out = id_err_q;
`endif

  assign rd_data                 = bus.m_rd_data_in;
  assign bus.e_rd_data_out       = rd_data;
  assign bus.e_rd_data_valid_out = data_valid;
  assign bus.e_rd_info_rdy_out   = info_rdy;
  assign bus.m_rd_data_rdy_out   = m_data_rdy;
  assign bus.m_rd_info_valid_out = (state_q == StHold);
  assign bus.m_rd_id_out         = m_id_q;
  assign bus.m_rd_addr_out       = m_addr_q;
  assign bus.m_rd_len_out        = m_len_q;

endmodule

// File: tb/tb_rd_arbiter.sv
// Directed bench for rd_arbiter: reset, single burst, round-robin, full FIFO,
// backpressure, reset mid-operation and (with RD_ARB_ID_CHECK_EN) ID checking.
module tb_rd_arbiter;
  import sw_pkg::*;

  localparam int unsigned NE = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned MO = 8;
  localparam int unsigned DW = 256;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rd_arbiter_if #(.NUM_ENGINES(NE), .ENG_IDX_W(IW), .DATA_W(DW)) bus ();

  rd_arbiter #(
    .NUM_ENGINES     (NE),
    .ENG_IDX_W       (IW),
    .MAX_OUTSTANDING (MO),
    .DATA_W          (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.e_rd_id_in         = '0;
    bus.e_rd_addr_in       = '0;
    bus.e_rd_len_in        = '0;
    bus.e_rd_info_valid_in = '0;
    bus.e_rd_data_rdy_in   = '1;
    bus.m_rd_info_rdy_in   = 1'b0;
    bus.m_rd_data_in       = '0;
    bus.m_rd_data_valid_in = 1'b0;
`ifdef RD_ARB_ID_CHECK_EN
    bus.m_rd_data_id_in    = '0;
`endif
  endtask

  task automatic set_req(input int e, input logic [5:0] id, input logic [31:0] addr,
                         input logic [7:0] len);
    bus.e_rd_id_in[e*6 +: 6]     = id;
    bus.e_rd_addr_in[e*32 +: 32] = addr;
    bus.e_rd_len_in[e*8 +: 8]    = len;
    bus.e_rd_info_valid_in[e]    = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [DW-1:0] beat_data(input int b);
    return {8{32'hA000_0000 + 32'(b)}};
  endfunction

  task automatic test_reset();
    do_reset();
    bus.m_rd_data_valid_in = 1'b1;
    settle();
    checks += 7;
    if (bus.m_rd_info_valid_out !== 1'b0) begin
      errors++; $display("FAIL reset_m_valid got %0b want 0", bus.m_rd_info_valid_out);
    end
    if (bus.m_rd_id_out !== 8'h00) begin
      errors++; $display("FAIL reset_m_id got %h want 00", bus.m_rd_id_out);
    end
    if (bus.m_rd_addr_out !== 32'h0) begin
      errors++; $display("FAIL reset_m_addr got %h want 0", bus.m_rd_addr_out);
    end
    if (bus.m_rd_len_out !== 8'h0) begin
      errors++; $display("FAIL reset_m_len got %h want 0", bus.m_rd_len_out);
    end
    if (bus.e_rd_info_rdy_out !== 4'b0000) begin
      errors++; $display("FAIL reset_e_rdy got %b want 0000", bus.e_rd_info_rdy_out);
    end
    if (bus.e_rd_data_valid_out !== 4'b0000) begin
      errors++; $display("FAIL reset_e_dvalid got %b want 0000", bus.e_rd_data_valid_out);
    end
    if (bus.m_rd_data_rdy_out !== 1'b0) begin
      errors++; $display("FAIL reset_m_drdy got %b want 0", bus.m_rd_data_rdy_out);
    end
`ifdef RD_ARB_ID_CHECK_EN
    checks++;
    if (bus.id_err_out !== 1'b0) begin
      errors++; $display("FAIL reset_id_err got %b want 0", bus.id_err_out);
    end
`endif
    bus.m_rd_data_valid_in = 1'b0;
  endtask

  task automatic test_single();
    logic [DW-1:0] exp_data;
    do_reset();
    set_req(2, 6'd5, 32'h1000, 8'd3);
    settle();
    checks += 2;
    if (bus.e_rd_info_rdy_out !== 4'b0100) begin
      errors++; $display("FAIL single_grant got %b want 0100", bus.e_rd_info_rdy_out);
    end
    if (bus.m_rd_info_valid_out !== 1'b0) begin
      errors++; $display("FAIL single_pre_valid got %b want 0", bus.m_rd_info_valid_out);
    end
    step();
    bus.e_rd_info_valid_in = '0;
    settle();
    checks += 5;
    if (bus.m_rd_info_valid_out !== 1'b1) begin
      errors++; $display("FAIL single_valid got %b want 1", bus.m_rd_info_valid_out);
    end
    if (bus.m_rd_id_out !== 8'h85) begin
      errors++; $display("FAIL single_id got %h want 85", bus.m_rd_id_out);
    end
    if (bus.m_rd_addr_out !== 32'h1000) begin
      errors++; $display("FAIL single_addr got %h want 1000", bus.m_rd_addr_out);
    end
    if (bus.m_rd_len_out !== 8'd3) begin
      errors++; $display("FAIL single_len got %0d want 3", bus.m_rd_len_out);
    end
    if (bus.e_rd_info_rdy_out !== 4'b0000) begin
      errors++; $display("FAIL single_hold_rdy got %b want 0000", bus.e_rd_info_rdy_out);
    end
    bus.m_rd_info_rdy_in = 1'b1;
    step();
    bus.m_rd_info_rdy_in = 1'b0;
    settle();
    checks++;
    if (bus.m_rd_info_valid_out !== 1'b0) begin
      errors++; $display("FAIL single_post_valid got %b want 0", bus.m_rd_info_valid_out);
    end
    bus.m_rd_data_valid_in = 1'b1;
    for (int b = 0; b < 4; b++) begin
      exp_data = beat_data(b);
      bus.m_rd_data_in = exp_data;
      settle();
      checks += 3;
      if (bus.e_rd_data_valid_out !== 4'b0100) begin
        errors++; $display("FAIL single_beat%0d_dvalid got %b want 0100", b,
                           bus.e_rd_data_valid_out);
      end
      if (bus.m_rd_data_rdy_out !== 1'b1) begin
        errors++; $display("FAIL single_beat%0d_drdy got %b want 1", b, bus.m_rd_data_rdy_out);
      end
      if (bus.e_rd_data_out !== exp_data) begin
        errors++; $display("FAIL single_beat%0d_data got %h want %h", b, bus.e_rd_data_out[31:0],
                           exp_data[31:0]);
      end
      step();
    end
    settle();
    checks += 2;
    if (bus.e_rd_data_valid_out !== 4'b0000) begin
      errors++; $display("FAIL single_drained_dvalid got %b want 0000", bus.e_rd_data_valid_out);
    end
    if (bus.m_rd_data_rdy_out !== 1'b0) begin
      errors++; $display("FAIL single_drained_drdy got %b want 0", bus.m_rd_data_rdy_out);
    end
    bus.m_rd_data_valid_in = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 6'(i), 32'(i * 256), 8'd0);
    bus.m_rd_info_rdy_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_rdy = 4'b0001 << (k % 4);
      settle();
      checks++;
      if (bus.e_rd_info_rdy_out !== exp_rdy) begin
        errors++; $display("FAIL rr_grant%0d got %b want %b", k, bus.e_rd_info_rdy_out, exp_rdy);
      end
      step();
      settle();
      checks += 3;
      if (bus.m_rd_info_valid_out !== 1'b1) begin
        errors++; $display("FAIL rr_valid%0d got %b want 1", k, bus.m_rd_info_valid_out);
      end
      if (bus.m_rd_id_out[7:6] !== 2'(k % 4)) begin
        errors++; $display("FAIL rr_idx%0d got %0d want %0d", k, bus.m_rd_id_out[7:6], k % 4);
      end
      if (bus.e_rd_info_rdy_out !== 4'b0000) begin
        errors++; $display("FAIL rr_hold%0d got %b want 0000", k, bus.e_rd_info_rdy_out);
      end
      step();
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 6'(i), 32'(i * 256), 8'd0);
    bus.m_rd_info_rdy_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      settle();
      checks++;
      if (bus.e_rd_info_rdy_out === 4'b0000) begin
        errors++; $display("FAIL full_fill%0d got %b want nonzero", k, bus.e_rd_info_rdy_out);
      end
      step();
      step();
    end
    for (int j = 0; j < 3; j++) begin
      settle();
      checks += 2;
      if (bus.e_rd_info_rdy_out !== 4'b0000) begin
        errors++; $display("FAIL full_block%0d got %b want 0000", j, bus.e_rd_info_rdy_out);
      end
      if (bus.m_rd_info_valid_out !== 1'b0) begin
        errors++; $display("FAIL full_mvalid%0d got %b want 0", j, bus.m_rd_info_valid_out);
      end
      step();
    end
    bus.m_rd_data_valid_in = 1'b1;
    settle();
    checks += 2;
    if (bus.e_rd_data_valid_out !== 4'b0001) begin
      errors++; $display("FAIL full_head got %b want 0001", bus.e_rd_data_valid_out);
    end
    if (bus.e_rd_info_rdy_out !== 4'b0000) begin
      errors++; $display("FAIL full_pop_cycle got %b want 0000", bus.e_rd_info_rdy_out);
    end
    step();
    bus.m_rd_data_valid_in = 1'b0;
    settle();
    checks++;
    if (bus.e_rd_info_rdy_out !== 4'b0001) begin
      errors++; $display("FAIL full_unblock got %b want 0001", bus.e_rd_info_rdy_out);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp_data;
    do_reset();
    set_req(1, 6'd9, 32'h2000, 8'd7);
    settle();
    checks++;
    if (bus.e_rd_info_rdy_out !== 4'b0010) begin
      errors++; $display("FAIL bp_grant got %b want 0010", bus.e_rd_info_rdy_out);
    end
    step();
    bus.e_rd_info_valid_in = '0;
    bus.m_rd_info_rdy_in   = 1'b1;
    step();
    bus.m_rd_info_rdy_in   = 1'b0;
    bus.m_rd_data_valid_in = 1'b1;
    for (int b = 0; b < 8; b++) begin
      exp_data = beat_data(16 + b);
      bus.m_rd_data_in = exp_data;
      if (b == 2) begin
        bus.e_rd_data_rdy_in[1] = 1'b0;
        for (int s = 0; s < 5; s++) begin
          settle();
          checks += 2;
          if (bus.m_rd_data_rdy_out !== 1'b0) begin
            errors++; $display("FAIL bp_stall%0d_drdy got %b want 0", s, bus.m_rd_data_rdy_out);
          end
          if (bus.e_rd_data_valid_out !== 4'b0010) begin
            errors++; $display("FAIL bp_stall%0d_dvalid got %b want 0010", s,
                               bus.e_rd_data_valid_out);
          end
          step();
        end
        bus.e_rd_data_rdy_in[1] = 1'b1;
      end
      settle();
      checks += 3;
      if (bus.e_rd_data_valid_out !== 4'b0010) begin
        errors++; $display("FAIL bp_beat%0d_dvalid got %b want 0010", b, bus.e_rd_data_valid_out);
      end
      if (bus.m_rd_data_rdy_out !== 1'b1) begin
        errors++; $display("FAIL bp_beat%0d_drdy got %b want 1", b, bus.m_rd_data_rdy_out);
      end
      if (bus.e_rd_data_out !== exp_data) begin
        errors++; $display("FAIL bp_beat%0d_data got %h want %h", b, bus.e_rd_data_out[31:0],
                           exp_data[31:0]);
      end
      step();
    end
    settle();
    checks++;
    if (bus.e_rd_data_valid_out !== 4'b0000) begin
      errors++; $display("FAIL bp_drained got %b want 0000", bus.e_rd_data_valid_out);
    end
    bus.m_rd_data_valid_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, 6'(i + 1), 32'(i * 256), 8'(i + 1));
    bus.m_rd_info_rdy_in = 1'b1;
    step();
    step();
    step();
    step();
    bus.m_rd_info_rdy_in = 1'b0;
    step();
    settle();
    checks += 2;
    if (bus.m_rd_info_valid_out !== 1'b1) begin
      errors++; $display("FAIL mid_hold got %b want 1", bus.m_rd_info_valid_out);
    end
    if (bus.m_rd_id_out !== 8'h83) begin
      errors++; $display("FAIL mid_hold_id got %h want 83", bus.m_rd_id_out);
    end
    bus.e_rd_info_valid_in = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    checks += 4;
    if (bus.m_rd_info_valid_out !== 1'b0) begin
      errors++; $display("FAIL mid_valid got %b want 0", bus.m_rd_info_valid_out);
    end
    if (bus.m_rd_id_out !== 8'h00) begin
      errors++; $display("FAIL mid_id got %h want 00", bus.m_rd_id_out);
    end
    if (bus.m_rd_addr_out !== 32'h0) begin
      errors++; $display("FAIL mid_addr got %h want 0", bus.m_rd_addr_out);
    end
    if (bus.m_rd_len_out !== 8'h0) begin
      errors++; $display("FAIL mid_len got %h want 0", bus.m_rd_len_out);
    end
    bus.m_rd_data_valid_in = 1'b1;
    settle();
    checks += 2;
    if (bus.e_rd_data_valid_out !== 4'b0000) begin
      errors++; $display("FAIL mid_fifo_empty got %b want 0000", bus.e_rd_data_valid_out);
    end
    if (bus.m_rd_data_rdy_out !== 1'b0) begin
      errors++; $display("FAIL mid_drdy got %b want 0", bus.m_rd_data_rdy_out);
    end
    bus.m_rd_data_valid_in = 1'b0;
    bus.e_rd_info_valid_in = 4'b1111;
    settle();
    checks++;
    if (bus.e_rd_info_rdy_out !== 4'b0001) begin
      errors++; $display("FAIL mid_rr_ptr got %b want 0001", bus.e_rd_info_rdy_out);
    end
    idle_inputs();
  endtask

`ifdef RD_ARB_ID_CHECK_EN
  task automatic test_id_check();
    do_reset();
    set_req(1, 6'd0, 32'h3000, 8'd0);
    step();
    bus.e_rd_info_valid_in = '0;
    bus.m_rd_info_rdy_in   = 1'b1;
    step();
    bus.m_rd_info_rdy_in   = 1'b0;
    bus.m_rd_data_valid_in = 1'b1;
    bus.m_rd_data_id_in    = {2'd3, 6'd0};
    settle();
    checks++;
    if (bus.id_err_out !== 1'b0) begin
      errors++; $display("FAIL idchk_before got %b want 0", bus.id_err_out);
    end
    step();
    bus.m_rd_data_valid_in = 1'b0;
    settle();
    checks++;
    if (bus.id_err_out !== 1'b1) begin
      errors++; $display("FAIL idchk_rise got %b want 1", bus.id_err_out);
    end
    step();
    step();
    settle();
    checks++;
    if (bus.id_err_out !== 1'b1) begin
      errors++; $display("FAIL idchk_sticky got %b want 1", bus.id_err_out);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_backpressure();
    test_reset_mid();
`ifdef RD_ARB_ID_CHECK_EN
    test_id_check();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
